counter: RTL and testbench
==========================

COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 5, count register width in bits (legal 2..32).
REQ-002 Parameter STEP, default 1, increment/decrement magnitude (1 ≤ STEP < 2^WIDTH).
REQ-003 clock  input  1  rising-edge system clock; all state updates on posedge clock only.
REQ-004 reset  input  1  asynchronous, active-low reset (count cleared while reset=0).
REQ-005 enable  input  1  count-enable; when 0, count holds.
REQ-006 up_dn  input  1  direction: 1 = count up, 0 = count down.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_val  input  WIDTH  value captured on load.
REQ-009 count  output  WIDTH  current count, driven directly from a register.
REQ-010 wrap  output  1  registered one-cycle pulse marking an overflow or underflow boundary crossing.
REQ-011 zero  output  1  combinational flag, 1 when count == 0.

Function
REQ-012 Priority per clock edge (reset=1): load > enable > hold.
REQ-013 load=1: count <= load_val next edge, regardless of enable/up_dn; wrap <= 0.
REQ-014 load=0, enable=1, up_dn=1: count <= (count + STEP) mod 2^WIDTH.
REQ-015 load=0, enable=1, up_dn=0: count <= (count - STEP) mod 2^WIDTH.
REQ-016 load=0, enable=0: count holds; wrap <= 0.
REQ-017 Latency: one clock from input sample to updated count; no combinational path from inputs to count or wrap.
REQ-018 wrap <= 1 for exactly one cycle when an up step has count + STEP ≥ 2^WIDTH, or a down step has count < STEP; otherwise wrap <= 0.
REQ-019 Arithmetic carried internally at WIDTH+1 bits; the carry/borrow bit drives wrap, and the low WIDTH bits become count.
REQ-020 Direction changes take effect on the same edge, with no dead cycle.
REQ-021 zero tracks count combinationally, including during reset.

Reset
REQ-022 reset=0 asynchronously forces count=0 and wrap=0, independent of clock.
REQ-023 While reset=0, all other inputs are ignored; zero=1.
REQ-024 Reset deassertion is synchronized internally with a 2-flop release synchronizer; the first count update occurs on the second posedge clock after reset rises.
REQ-025 Reset asserted mid-count aborts any pending load or step; no wrap pulse is generated.

Configuration
REQ-026 Macro COUNTER_SATURATE_EN: when defined, an up step saturates at 2^WIDTH-1 and a down step saturates at 0, instead of wrapping; in a step that would have wrapped, count takes the saturation value and wrap pulses once for that step.
REQ-027 With the macro defined, further steps while saturated hold count and assert wrap on each such step.
REQ-028 Without COUNTER_SATURATE_EN, modulo wrap per REQ-014/015 applies; default build leaves the macro undefined.

Verification
REQ-029 Parameters WIDTH=5, STEP=1: reset=0, then release; enable=1, up_dn=1 for 40 cycles -> count 0..31, then 0..7; wrap pulses once, on the edge where count goes 31->0.
REQ-030 At count=3, up_dn=0, enable=1 for 5 cycles -> count 2,1,0,31,30; wrap pulses on the 0->31 edge; zero=1 only while count=0.
REQ-031 load=1, load_val=17, enable=1, up_dn=1 on the same edge -> count=17 (load wins); next edge with load=0 -> count=18.
REQ-032 At count=12, drive reset=0 between clock edges -> count=0 immediately, without waiting for a clock edge; after release, count stays 0 until the second posedge, then increments.
REQ-033 Build with COUNTER_SATURATE_EN, STEP=4, load 30, count up -> count=31 with wrap=1; next step -> count=31 with wrap=1; count down from 2 -> 0 with wrap=1.
REQ-034 enable=0 for 10 cycles with up_dn toggling -> count constant, wrap=0 throughout.

Source files
------------

// File: rtl/counter.sv
// counter: up/down counter with a synchronous load and a registered wrap pulse.
//
// Parameters
//   WIDTH    count register width in bits (2..32)
//   STEP     increment/decrement magnitude (1 <= STEP < 2**WIDTH)
//
// Ports
//   clock    rising-edge system clock
//   reset    asynchronous active-low reset; clears count and wrap at once
//   enable   count-enable; count holds when low
//   up_dn    direction, 1 = up, 0 = down
//   load     synchronous load strobe, takes priority over enable
//   load_val value captured on load
//   count    current count, straight from a register
//   wrap     one-cycle registered pulse on an overflow/underflow step
//   zero     combinational flag, high while count == 0
//
// Build option
//   COUNTER_SATURATE_EN  when defined, steps saturate at all-ones / zero
//                        instead of wrapping, and wrap pulses on every step
//                        that hits the limit. Undefined by default.
module counter #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned STEP  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             zero
);

    localparam int unsigned XW = WIDTH + 1;
    localparam logic [XW-1:0] STEP_X = XW'(STEP);

    logic [1:0]       rel_q;
    logic             run;
    logic [XW-1:0]    sum_x;
    logic [XW-1:0]    diff_x;
    logic [WIDTH-1:0] count_d;
    logic             wrap_d;

    // Two-stage release of the async reset. Counting may start once the
    // first stage has captured the release, so the first update lands on
    // the second rising edge after reset goes high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rel_q <= '0;
        end else begin
            rel_q <= {rel_q[0], 1'b1};
        end
    end

    assign run = rel_q[0] | rel_q[1];

    // One-bit-wider arithmetic: the top bit is the carry (up) or borrow (down).
    assign sum_x  = {1'b0, count} + STEP_X;
    assign diff_x = {1'b0, count} - STEP_X;

    // Next count / wrap: load beats enable beats hold.
    always_comb begin
        count_d = count;
        wrap_d  = 1'b0;
        if (run) begin
            if (load) begin
                count_d = load_val;
            end else if (enable) begin
                if (up_dn) begin
                    wrap_d  = sum_x[WIDTH];
                    count_d = sum_x[WIDTH-1:0];
`ifdef COUNTER_SATURATE_EN
                    if (sum_x[WIDTH]) begin
                        count_d = '1;
                    end
`endif
                end else begin
                    wrap_d  = diff_x[WIDTH];
                    count_d = diff_x[WIDTH-1:0];
`ifdef COUNTER_SATURATE_EN
                    if (diff_x[WIDTH]) begin
                        count_d = '0;
                    end
`endif
                end
            end
        end
    end

    // Count and wrap registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_d;
            wrap  <= wrap_d;
        end
    end

    assign zero = (count == '0);

endmodule

// File: tb/tb_counter.sv
// tb_counter: directed self-checking bench for counter (WIDTH=5, STEP=1).
// With COUNTER_SATURATE_EN defined, a second instance (STEP=4) is exercised
// for the saturating behaviour.
module tb_counter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       up_dn = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_val = '0;
    logic [4:0] count;
    logic       wrap;
    logic       zero;

    logic       s_enable = 1'b0;
    logic       s_up_dn = 1'b0;
    logic       s_load = 1'b0;
    logic [4:0] s_load_val = '0;
    logic [4:0] s_count;
    logic       s_wrap;
    logic       s_zero;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    counter #(.WIDTH(5), .STEP(1)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap     (wrap),
        .zero     (zero)
    );

    counter #(.WIDTH(5), .STEP(4)) dut_s (
        .clock    (clock),
        .reset    (reset),
        .enable   (s_enable),
        .up_dn    (s_up_dn),
        .load     (s_load),
        .load_val (s_load_val),
        .count    (s_count),
        .wrap     (s_wrap),
        .zero     (s_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [4:0] exp_cnt;
        logic       exp_wrap;
        int         wraps;
        logic [4:0] down_exp [5];
        logic       down_wrap [5];

        // Asynchronous reset with no clock edge involved.
        #2 reset = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);

        // Inputs ignored while reset is low.
        enable = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 5'd9;
        step();
        step();
        check("rst_ignore_count", 32'(count), 32'd0);
        check("rst_ignore_zero", 32'(zero), 32'd1);

        // Release between edges; first update on the second edge after.
        load = 1'b0;
        #3 reset = 1'b1;
        step();
        check("release_edge1", 32'(count), 32'd0);

        // 40 up steps: 1..31, 0..8, one wrap on 31->0.
        exp_cnt = 5'd0;
        wraps = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            exp_wrap = (exp_cnt == 5'd31);
            exp_cnt  = exp_cnt + 5'd1;
            check("up_count", 32'(count), 32'(exp_cnt));
            check("up_wrap", 32'(wrap), 32'(exp_wrap));
            check("up_zero", 32'(zero), 32'(exp_cnt == 5'd0));
            if (wrap === 1'b1) wraps++;
        end
        check("up_wrap_total", 32'(wraps), 32'd1);
        check("up_final", 32'(count), 32'd8);

        // Hold with enable low while direction toggles.
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            up_dn = ~up_dn;
            step();
            check("hold_count", 32'(count), 32'd8);
            check("hold_wrap", 32'(wrap), 32'd0);
        end

        // Load 3, then count down across zero.
        load = 1'b1; load_val = 5'd3;
        step();
        check("load3", 32'(count), 32'd3);
        load = 1'b0; enable = 1'b1; up_dn = 1'b0;
        down_exp[0] = 5'd2;  down_wrap[0] = 1'b0;
        down_exp[1] = 5'd1;  down_wrap[1] = 1'b0;
        down_exp[2] = 5'd0;  down_wrap[2] = 1'b0;
        down_exp[3] = 5'd31; down_wrap[3] = 1'b1;
        down_exp[4] = 5'd30; down_wrap[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("down_count", 32'(count), 32'(down_exp[i]));
            check("down_wrap", 32'(wrap), 32'(down_wrap[i]));
            check("down_zero", 32'(zero), 32'(down_exp[i] == 5'd0));
        end

        // Direction change takes effect on the very next edge.
        up_dn = 1'b1;
        step();
        check("dir_change", 32'(count), 32'd31);

        // Load wins over enable; then resume counting.
        load = 1'b1; load_val = 5'd17;
        step();
        check("load_wins", 32'(count), 32'd17);
        check("load_wrap", 32'(wrap), 32'd0);
        load = 1'b0;
        step();
        check("after_load", 32'(count), 32'd18);

        // Load at the top with up enabled: no wrap pulse.
        load = 1'b1; load_val = 5'd31;
        step();
        load_val = 5'd5;
        step();
        check("load_at_top", 32'(count), 32'd5);
        check("load_at_top_wrap", 32'(wrap), 32'd0);

        // Reset mid-count between edges, with a load pending.
        load_val = 5'd12;
        step();
        load = 1'b0; enable = 1'b0;
        check("pre_reset", 32'(count), 32'd12);
        load = 1'b1; load_val = 5'd9; enable = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("mid_reset_count", 32'(count), 32'd0);
        check("mid_reset_zero", 32'(zero), 32'd1);
        check("mid_reset_wrap", 32'(wrap), 32'd0);
        step();
        check("reset_held", 32'(count), 32'd0);
        load = 1'b0; up_dn = 1'b1;
        #3 reset = 1'b1;
        step();
        check("rerelease_edge1", 32'(count), 32'd0);
        check("rerelease_wrap", 32'(wrap), 32'd0);
        step();
        check("rerelease_edge2", 32'(count), 32'd1);
        enable = 1'b0;

`ifdef COUNTER_SATURATE_EN
        // Saturating build, STEP=4.
        s_load = 1'b1; s_load_val = 5'd30;
        step();
        check("sat_load", 32'(s_count), 32'd30);
        s_load = 1'b0; s_enable = 1'b1; s_up_dn = 1'b1;
        step();
        check("sat_up_count", 32'(s_count), 32'd31);
        check("sat_up_wrap", 32'(s_wrap), 32'd1);
        step();
        check("sat_hold_count", 32'(s_count), 32'd31);
        check("sat_hold_wrap", 32'(s_wrap), 32'd1);
        s_up_dn = 1'b0;
        step();
        check("sat_down_mid", 32'(s_count), 32'd27);
        check("sat_down_mid_wrap", 32'(s_wrap), 32'd0);
        s_load = 1'b1; s_load_val = 5'd2;
        step();
        s_load = 1'b0;
        step();
        check("sat_down_count", 32'(s_count), 32'd0);
        check("sat_down_wrap", 32'(s_wrap), 32'd1);
        s_enable = 1'b0;
`else
        check("wide_idle", 32'(s_count), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
